// File: rtl/pipe_ex.sv
// pipe_ex: three-stage pipeline computing F = ((A + B) + (C - D)) * D modulo 2^N.
// A valid bit travels with the data; a global enable stalls every stage at once.
module pipe_ex #(
    parameter int unsigned N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    output logic [N-1:0] F,
    output logic         out_valid
);

    // Stage 1 registers
    logic [N-1:0] s1_x1;
    logic [N-1:0] s1_x2;
    logic [N-1:0] s1_d;
    logic         s1_v;

    // Stage 2 registers
    logic [N-1:0] s2_x3;
    logic [N-1:0] s2_d;
    logic         s2_v;

    // Stage-to-stage arithmetic, all truncated to N bits (modulo 2^N)
    logic [N-1:0] sum_ab_c;
    logic [N-1:0] diff_cd_c;
    logic [N-1:0] sum_x_c;
    logic [N-1:0] prod_c;

    // Combinational datapath between register ranks; carries and high product bits drop
    always_comb begin
        sum_ab_c  = N'(A + B);
        diff_cd_c = N'(C - D);
        sum_x_c   = N'(s1_x1 + s1_x2);
        prod_c    = N'(s2_x3 * s2_d);
    end

    // Stage 1: operand sums/difference; data loads every enabled cycle, valid just rides along
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x1 <= '0;
            s1_x2 <= '0;
            s1_d  <= '0;
            s1_v  <= 1'b0;
        end else if (en) begin
            s1_x1 <= sum_ab_c;
            s1_x2 <= diff_cd_c;
            s1_d  <= D;
            s1_v  <= in_valid;
        end
    end

    // Stage 2: combine partial results, forward multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_x3 <= '0;
            s2_d  <= '0;
            s2_v  <= 1'b0;
        end else if (en) begin
            s2_x3 <= sum_x_c;
            s2_d  <= s1_d;
            s2_v  <= s1_v;
        end
    end

    // Stage 3: final product into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F         <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            F         <= prod_c;
            out_valid <= s2_v;
        end
    end

endmodule

// File: tb/tb_pipe_ex.sv
// tb_pipe_ex: directed stimulus with a scoreboard queue of expected results.
module tb_pipe_ex;

    localparam int unsigned N = 10;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [N-1:0] F;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned exp_q[$];
    bit [2:0]    hist;          // enabled-edge history of in_valid, bit 2 = at output
    bit          exp_ov;
    int unsigned last_f;

    pipe_ex #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .F         (F),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned model(int unsigned a, int unsigned b,
                                          int unsigned c, int unsigned d);
        int unsigned t;
        t = ((a + b) + (c + 1024 - d)) % 1024;
        return (t * d) % 1024;
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        hist   = 3'b000;
        exp_ov = 1'b0;
        last_f = 0;
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later and score
    task automatic step(input string tag, input bit e, input bit v,
                        input int unsigned a, input int unsigned b,
                        input int unsigned c, input int unsigned d);
        en       = e;
        in_valid = v;
        A        = N'(a);
        B        = N'(b);
        C        = N'(c);
        D        = N'(d);
        if (e) begin
            hist = {hist[1:0], v};
            if (v) exp_q.push_back(model(a, b, c, d));
        end
        @(posedge clk);
        #1;
        if (e) begin
            exp_ov = hist[2];
            check({tag, "_ov"}, 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_underflow"}, 1, 0);
                end else begin
                    last_f = exp_q.pop_front();
                    check({tag, "_f"}, 32'(F), last_f);
                end
            end
        end else begin
            check({tag, "_stall_ov"}, 32'(out_valid), 32'(exp_ov));
            if (exp_ov) check({tag, "_stall_f"}, 32'(F), last_f);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        A = '0; B = '0; C = '0; D = '0;
        model_clear();

        // Reset state
        #12;
        check("rst_f", 32'(F), 0);
        check("rst_ov", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic latency: one valid set, F stays 0 until the 3rd edge
        step("lat0", 1, 1, 10, 12, 6, 3);
        check("lat0_fzero", 32'(F), 0);
        step("lat1", 1, 0, 0, 0, 0, 0);
        check("lat1_fzero", 32'(F), 0);
        step("lat2", 1, 0, 0, 0, 0, 0);
        check("lat2_f75", 32'(F), 75);

        // Back-to-back streaming
        step("str0", 1, 1, 10, 12, 6, 3);
        step("str1", 1, 1, 10, 10, 5, 3);
        step("str2", 1, 1, 20, 11, 1, 4);
        check("str2_f75", 32'(F), 75);
        step("str3", 1, 0, 0, 0, 0, 0);
        check("str3_f66", 32'(F), 66);
        step("str4", 1, 0, 0, 0, 0, 0);
        check("str4_f112", 32'(F), 112);

        // Wrap-around cases
        step("wrp0", 1, 1, 5, 0, 1, 4);
        step("wrp1", 1, 1, 1023, 1, 0, 0);
        step("wrp2", 1, 1, 1000, 0, 0, 2);
        check("wrp2_f8", 32'(F), 8);
        step("wrp3", 1, 0, 0, 0, 0, 0);
        check("wrp3_f0", 32'(F), 0);
        step("wrp4", 1, 0, 0, 0, 0, 0);
        check("wrp4_f972", 32'(F), 972);

        // Stall with items in flight
        step("stl0", 1, 1, 7, 8, 9, 5);
        step("stl1", 1, 1, 100, 200, 50, 7);
        step("stl2", 1, 1, 3, 4, 2, 9);
        step("stl3", 0, 1, 999, 999, 999, 999);
        step("stl4", 0, 0, 111, 222, 333, 444);
        step("stl5", 1, 0, 0, 0, 0, 0);
        step("stl6", 1, 0, 0, 0, 0, 0);
        step("stl7", 1, 0, 0, 0, 0, 0);

        // Valid gating with changing operands
        for (int i = 0; i < 8; i++) begin
            step("vg", 1, (i % 2) == 0, 17 * i + 3, 31 * i, 5 * i + 1, i + 2);
        end
        step("vgf0", 1, 0, 1, 2, 3, 4);
        step("vgf1", 1, 0, 5, 6, 7, 8);
        step("vgf2", 1, 0, 9, 10, 11, 12);

        // Asynchronous reset mid-flight
        step("ar0", 1, 1, 10, 12, 6, 3);
        step("ar1", 1, 1, 20, 11, 1, 4);
        step("ar2", 1, 1, 10, 10, 5, 3);
        check("ar2_f75", 32'(F), 75);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_imm_f", 32'(F), 0);
        check("ar_imm_ov", 32'(out_valid), 0);
        model_clear();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("arpost", 1, 0, 40 + i, 3, 2, 5);
        end

        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
